reg_bank_arbiter: RTL

Shares the single configuration/status register bank between the two serial host peripherals: SPI is requester 0 and I2C is requester 1. It replaces the fixed-select mux between them. It grants one access at a time using round-robin with an optional bounded burst lock, drives the bank's write strobe, address and write data, and returns captured read data to the owning requester.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/reg_bank_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg
// Shared types and constants for the register-bank arbiter slice.
//   arb_state_t   : arbiter FSM state encoding
//   REQ_SPI/I2C   : requester index of each host peripheral
//   DEF_*         : default widths and burst limit
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int REQ_SPI = 0;
  localparam int REQ_I2C = 1;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_REG_W     = 8;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin pick, purely combinational.
//   req     in  2  request vector, requester 0 in bit 0
//   last    in  1  index granted most recently
//   gnt_vld out 1  at least one requester is asking
//   gnt_idx out 1  winning requester index
module rr_arbiter2
  import reg_bank_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = 1'b0;
    if (&req) begin
      // tie: whoever was not served last goes next
      gnt_idx = ~last;
    end else if (req[REQ_I2C]) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Shares one configuration/status register bank between SPI (requester 0)
// and I2C (requester 1). One access at a time, round-robin with an optional
// bounded burst lock for the current owner.
//   clk, rst                 clock, synchronous active-high reset
//   ena                      low blocks new grants; in-flight access finishes
//   req, lock, wr_rdn        per-requester request, burst hint, 1=write
//   addr, wdata              per-requester command, requester 0 in the LSBs
//   ack, rdata               one-cycle ack to owner with captured read data
//   owner, busy              current/last owner, high in ACCESS and RESP
//   bank_we/addr/wdata       bank write strobe, address, write data
//   bank_rdata               bank combinational read data
//
// state  | meaning
// IDLE   | waiting for an enabled request
// ACCESS | command register drives the bank, read data captured
// RESP   | ack to owner; may chain straight into another ACCESS
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int REG_W     = DEF_REG_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [1:0]          req,
  input  logic [1:0]          lock,
  input  logic [1:0]          wr_rdn,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*REG_W-1:0]  wdata,
  output logic [1:0]          ack,
  output logic [REG_W-1:0]    rdata,
  output logic                owner,
  output logic                busy,
  output logic                bank_we,
  output logic [ADDR_W-1:0]   bank_addr,
  output logic [REG_W-1:0]    bank_wdata,
  input  logic [REG_W-1:0]    bank_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_TOP = CNT_W'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic              owner_q, last_q;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [REG_W-1:0]  cmd_wdata_q;
  logic [REG_W-1:0]  rdata_q;
  logic              ena_lost_q;

  logic              gnt_vld, gnt_idx;
  logic              chain, load_cmd, load_idx;
  logic [ADDR_W-1:0] req_addr [2];
  logic [REG_W-1:0]  req_wdata [2];

  always_comb begin
    req_addr[0]  = addr[ADDR_W-1:0];
    req_addr[1]  = addr[2*ADDR_W-1:ADDR_W];
    req_wdata[0] = wdata[REG_W-1:0];
    req_wdata[1] = wdata[2*REG_W-1:REG_W];
  end

  rr_arbiter2 u_rr (
    .req     (req),
    .last    (last_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    load_idx = owner_q;
    chain    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && gnt_vld) begin
          state_d  = ACCESS;
          load_cmd = 1'b1;
          load_idx = gnt_idx;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        // the other side may only be held off for MAX_BURST accesses in a row
        chain = ena && !ena_lost_q && req[owner_q] && lock[owner_q] &&
                (!req[~owner_q] || (burst_cnt_q < BURST_TOP));
        state_d  = chain ? ACCESS : IDLE;
        load_cmd = chain;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      ena_lost_q  <= 1'b0;
    end else begin
      if (load_cmd) begin
        cmd_we_q    <= wr_rdn[load_idx];
        cmd_addr_q  <= req_addr[load_idx];
        cmd_wdata_q <= req_wdata[load_idx];
        owner_q     <= load_idx;
      end
      if (state_q == IDLE && load_cmd) begin
        last_q      <= gnt_idx;
        burst_cnt_q <= '0;
      end else if (chain && (burst_cnt_q != BURST_TOP)) begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
      if (state_q == ACCESS) begin
        rdata_q    <= bank_rdata;
        // an enable drop anywhere in the access forbids chaining from RESP
        ena_lost_q <= !ena;
      end
    end
  end

  always_comb begin
    ack = 2'b00;
    if (state_q == RESP) begin
      ack[owner_q] = 1'b1;
    end
  end

  assign rdata      = rdata_q;
  assign owner      = owner_q;
  assign busy       = (state_q != IDLE);
  assign bank_we    = (state_q == ACCESS) && cmd_we_q;
  assign bank_addr  = cmd_addr_q;
  assign bank_wdata = cmd_wdata_q;

endmodule
